// File: rtl/parity_rx_pkg.sv
// Shared types and line levels for the even-parity serial receiver.
package parity_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register; flags overrun when a write hits a full,
// un-drained buffer. The payload is opaque so other receivers can reuse it.
module rx_out_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_rdy_i,
  output logic [W-1:0] rd_data_o,
  output logic         rd_vld_o,
  output logic         overrun_o
);
  logic [W-1:0] data_q, data_d;
  logic         vld_q, vld_d;
  logic         ovr_q, ovr_d;
  logic         accept;

  // A pop in the same cycle frees the slot for the incoming word.
  always_comb begin
    accept = wr_en_i && (!vld_q || rd_rdy_i);
    data_d = accept ? wr_data_i : data_q;
    vld_d  = accept || (vld_q && !rd_rdy_i);
    ovr_d  = wr_en_i && vld_q && !rd_rdy_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign rd_data_o = data_q;
  assign rd_vld_o  = vld_q;
  assign overrun_o = ovr_q;
endmodule

// File: rtl/even_parity_rx.sv
// Even-parity framed serial receiver: start, DATA_W bits LSB first, parity, stop.
// Completed frames (errors included) go to a one-entry output buffer.
module even_parity_rx
  import parity_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_vld,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  input  logic              data_rdy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic              done, ferr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    perr_d  = perr_q;
    done    = 1'b0;
    ferr    = 1'b0;
    if (bit_vld) begin
      unique case (state_q)
        IDLE: if (bit_in == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
        DATA: begin
          // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
          shift_d = DATA_W'({bit_in, shift_q} >> 1);
          acc_d   = acc_q ^ bit_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          perr_d  = acc_q ^ bit_in;
          state_d = STOP;
        end
        STOP: begin
          done    = 1'b1;
          ferr    = (bit_in != STOP_BIT);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      perr_q  <= perr_d;
    end
  end

  rx_out_buf #(.W(DATA_W + 2)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (done),
    .wr_data_i ({ferr, perr_q, shift_q}),
    .rd_rdy_i  (data_rdy),
    .rd_data_o ({frame_err, parity_err, data_out}),
    .rd_vld_o  (data_vld),
    .overrun_o (overrun)
  );

  assign busy = (state_q != IDLE);
endmodule

// File: doc/even_parity_rx.md
Name: even_parity_rx

Overview:
- Serial receiver and checker for even-parity framed data. It is the receive-side counterpart of the combinational even-parity generator.
- Accepts a pre-sampled serial bit stream, one bit per `bit_vld` strobe. Frame format is: start bit (0), DATA_W data bits LSB first, even-parity bit, stop bit (1).
- Delivers each received word through a one-entry valid/ready output buffer, with parity-error, framing-error and overrun flags.
- Sits behind a line sampler and in front of any word-level consumer.

Parameters:
- DATA_W, 8: data bits per frame; legal range 1..32.
- CNT_W, $clog2(DATA_W+1): width of the bit counter (derived; not overridden by users).

Ports:
- clk  in  1  single system clock; rising edge active.
- rst  in  1  synchronous, active-high reset.
- bit_vld  in  1  one-cycle strobe; `bit_in` is meaningful only when this is high.
- bit_in  in  1  serial line bit; line idles high.
- data_out  out  DATA_W  received word; held stable while `data_vld` is high.
- data_vld  out  1  buffered word available.
- data_rdy  in  1  consumer accepts the word; transfer occurs when `data_vld && data_rdy`.
- parity_err  out  1  qualified by `data_vld`; high if data ones + parity bit is odd.
- frame_err  out  1  qualified by `data_vld`; high if the stop bit was sampled as 0.
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the buffer was full.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, `rst` high at a clk edge):
  - FSM goes to IDLE; bit counter, shift register and parity accumulator are cleared.
  - `data_out`=0, `data_vld`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - Reset mid-frame discards the partial frame and any buffered word.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with `bit_vld`=1; without a strobe, state is held.
  - IDLE: `bit_in`=1 stays IDLE. `bit_in`=0 is taken as the start bit → DATA; counter and accumulator are cleared.
  - DATA: shift `bit_in` into the MSB of the shift register (LSB-first reception), XOR it into the accumulator, increment the counter. After the DATA_W-th data bit → PARITY.
  - PARITY: record `perr = acc ^ bit_in` → STOP.
  - STOP: record `ferr = ~bit_in`. Complete the frame → IDLE, regardless of the stop-bit value.
- Frame completion (the STOP-state strobe cycle), evaluated at the same clk edge:
  - Buffer empty, or `data_vld && data_rdy` in this cycle: load `data_out`/`parity_err`/`frame_err`; `data_vld`=1 on the next cycle.
  - Buffer full and `data_rdy`=0: the new frame is dropped; the buffered word and its flags are unchanged; `overrun`=1 for exactly one cycle.
- Latency: `data_vld` rises one clk after the stop-bit strobe.
- Output handshake:
  - `data_vld` stays high until a cycle with `data_rdy`=1. It then falls on the next edge, unless a new frame completes in that same cycle.
  - `data_rdy` while `data_vld`=0 has no effect.
- Frames with `parity_err` or `frame_err` set are still delivered, with the flags set.
- After a bad stop bit, the FSM returns to IDLE. The next 0 strobe is treated as a new start bit; there is no break detection.
- Back-to-back frames are supported: a start-bit strobe is accepted on the cycle immediately after the stop strobe.
- `bit_vld` may be asserted on consecutive cycles. A gap of any length between strobes is legal mid-frame; there is no timeout.

Decomposition:
- Package `parity_rx_pkg`:
  - state enum `rx_state_t` {IDLE, DATA, PARITY, STOP};
  - localparams `START_BIT`=1'b0, `STOP_BIT`=1'b1, `IDLE_LVL`=1'b1.
- One natural sub-module: `rx_out_buf`, the one-entry valid/ready holding register with overrun detection. It is reusable by other receivers in the codebase.
- Frame FSM, shifter and parity accumulator stay in the top module.

Test Plan:
- Clean 0xA5 (DATA_W=8), back-to-back strobes; bits 0,1,0,1,0,0,1,0,1,0(par),1(stop); `data_rdy`=1 → `data_out`=0xA5, `data_vld` for 1 cycle, one clk after the stop strobe; `parity_err`=0, `frame_err`=0.
- Parity error: 0x07 sent with parity bit 0 (correct is 1) → `data_out`=0x07, `parity_err`=1, `frame_err`=0. Repeat with parity 1 → `parity_err`=0.
- Framing error: 0x3C, parity 0, stop bit 0 → `frame_err`=1. An immediately following clean 0x01 frame (parity 1) is received correctly.
- Backpressure/overrun, `data_rdy`=0:
  - Send 0x11 then 0x22 → `data_out` stays 0x11; `overrun` pulses once at 0x22 completion.
  - Then `data_rdy`=1 → 0x11 is accepted and `data_vld` falls.
  - Simultaneous case: `data_rdy`=1 in the completion cycle of 0x33 → 0x33 is loaded and `overrun` stays 0.
- Reset mid-frame and idle noise: assert `rst` after 4 data bits of 0xFF → `busy`=0 and no output. Then idle 1-strobes with random `bit_vld` gaps, then 0x5A with 3-cycle inter-strobe gaps → `data_out`=0x5A with no errors.
